alu_exec_ctrl: RTL and testbench

- Multicycle execute controller that drives the ALU's operand, opcode, opext and carry inputs.
- Consumes the ALU's S and CLFZN outputs and writes S back into an internal 16x16 register file.
- Holds the processor status register (PSR) and feeds its carry bit back to the ALU.
- Accepts one 16-bit instruction at a time through a valid/ready handshake; sits between fetch and the combinational ALU.

---
 rtl/alu_exec_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_exec_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Multicycle execute controller: reads operands from a 16x16 register file, drives an
// external combinational ALU, and writes the result and flags back four cycles per instruction.
module alu_exec_ctrl #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_opext,
  output logic             alu_carry,
  input  logic [WIDTH-1:0] alu_S,
  input  logic [4:0]       alu_CLFZN,
  output logic             done,
  output logic             illegal,
  output logic [4:0]       psr,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t           state;
  logic [15:0]      instr_q;
  logic [WIDTH-1:0] s_hold;
  logic [4:0]       clfzn_hold;
  logic [WIDTH-1:0] regs [NREGS];

  logic [3:0] opcode, rdest, opext, rsrc;
  logic [7:0] imm8;

  assign opcode = instr_q[15:12];
  assign rdest  = instr_q[11:8];
  assign opext  = instr_q[7:4];
  assign rsrc   = instr_q[3:0];
  assign imm8   = instr_q[7:0];

  assign dbg_data = regs[dbg_addr];

  function automatic logic is_legal(input logic [3:0] op, input logic [3:0] ext);
    logic ok;
    ok = 1'b0;
    case (op)
      4'b0101, 4'b0110, 4'b0111: ok = 1'b1;
      4'b0000: ok = (ext == 4'b0101) || (ext == 4'b0110) || (ext == 4'b0111);
      4'b1010: ok = (ext == 4'b0101) || (ext == 4'b0110);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // NOTE: every register here uses non-blocking assignment so all state updates
  // at the edge see the same pre-edge values (e.g. operand read before writeback).
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr_q     <= '0;
      s_hold      <= '0;
      clfzn_hold  <= '0;
      psr         <= '0;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      illegal     <= 1'b0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_opcode  <= '0;
      alu_opext   <= '0;
      alu_carry   <= 1'b0;
      // NOTE: the register file is architecturally cleared on reset, so it is
      // built from flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_q     <= instr_in;
            instr_ready <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          alu_A      <= regs[rdest];
          alu_opcode <= opcode;
          alu_opext  <= opext;
          alu_carry  <= psr[4];
          case (opcode)
            4'b0101, 4'b0111: alu_B <= {{(WIDTH-8){imm8[7]}}, imm8};
            4'b0110:          alu_B <= {{(WIDTH-8){1'b0}}, imm8};
            default:          alu_B <= regs[rsrc];
          endcase
          state <= EXEC;
        end
        EXEC: begin
          s_hold     <= alu_S;
          clfzn_hold <= alu_CLFZN;
          done       <= 1'b1;
          illegal    <= !is_legal(opcode, opext);
          state      <= WB;
        end
        WB: begin
          // illegal is already high for this cycle, so it gates the commit directly
          if (!illegal) begin
            regs[rdest] <= s_hold;
            psr         <= clfzn_hold;
          end
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: a behavioural ALU drives alu_S/alu_CLFZN, and a
// register-file/PSR reference model predicts every port value through each instruction.
module tb_alu_exec_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_A, alu_B, alu_S;
  logic [3:0]  alu_opcode, alu_opext;
  logic        alu_carry;
  logic [4:0]  alu_CLFZN;
  logic        done, illegal;
  logic [4:0]  psr;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_regs [16];
  logic [4:0]  m_psr;

  alu_exec_ctrl #(.NREGS(16), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_opext(alu_opext), .alu_carry(alu_carry), .alu_S(alu_S), .alu_CLFZN(alu_CLFZN),
    .done(done), .illegal(illegal), .psr(psr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Returns {C,L,F,Z,N,S}. Compare-class opcode 1010 subtracts; adds with carry use cin.
  function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op, input logic [3:0] ext,
                                         input logic cin);
    int unsigned sum;
    logic [15:0] s;
    logic c, l, f, z, n, sub, use_c;
    sub   = (op == 4'hA);
    use_c = (op == 4'h7) || (op == 4'h0 && ext == 4'h7);
    if (sub) sum = 32'(a) - 32'(b);
    else     sum = 32'(a) + 32'(b) + ((use_c && cin) ? 1 : 0);
    s = sum[15:0];
    c = sum[16];
    l = sub ? (a < b) : 1'b0;
    f = sub ? (a[15] != b[15] && s[15] != a[15]) : (a[15] == b[15] && s[15] != a[15]);
    z = (s == 16'h0);
    n = s[15];
    return {c, l, f, z, n, s};
  endfunction

  always_comb {alu_CLFZN, alu_S} = alu_fn(alu_A, alu_B, alu_opcode, alu_opext, alu_carry);

  function automatic bit ref_legal(input logic [15:0] ins);
    case (ins[15:12])
      4'h5, 4'h6, 4'h7: return 1'b1;
      4'h0:             return ins[7:4] inside {4'h5, 4'h6, 4'h7};
      4'hA:             return ins[7:4] inside {4'h5, 4'h6};
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] ref_b(input logic [15:0] ins);
    logic signed [7:0] simm;
    int v;
    simm = ins[7:0];
    v    = simm;
    case (ins[15:12])
      4'h5, 4'h7: return v[15:0];
      4'h6:       return {8'h00, ins[7:0]};
      default:    return m_regs[ins[3:0]];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic sweep_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check(tag, dbg_data, m_regs[i]);
    end
  endtask

  // Full handshake for one instruction; optionally keeps instr_valid high while busy.
  task automatic issue(input logic [15:0] ins, input bit hold);
    logic [3:0]  rd;
    logic [15:0] a, b;
    logic [20:0] r;
    bit          lg;
    int          n;
    rd = ins[11:8];
    n  = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!instr_ready) check("ready_wait", {31'b0, instr_ready}, 32'd1);
    a  = m_regs[rd];
    b  = ref_b(ins);
    lg = ref_legal(ins);
    r  = alu_fn(a, b, ins[15:12], ins[7:4], m_psr[4]);
    instr_in = ins; instr_valid = 1'b1; dbg_addr = rd;
    @(posedge clk); #1;
    check("ready_read", {31'b0, instr_ready}, 32'd0);
    check("done_read", {31'b0, done}, 32'd0);
    if (hold) instr_in = 16'($urandom);
    else      instr_valid = 1'b0;
    @(posedge clk); #1;
    check("alu_A", alu_A, a);
    check("alu_B", alu_B, b);
    check("alu_opcode", alu_opcode, ins[15:12]);
    check("alu_opext", alu_opext, ins[7:4]);
    check("alu_carry", {31'b0, alu_carry}, {31'b0, m_psr[4]});
    check("done_exec", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    check("done_wb", {31'b0, done}, 32'd1);
    check("illegal_wb", {31'b0, illegal}, {31'b0, !lg});
    check("ready_wb", {31'b0, instr_ready}, 32'd0);
    check("dbg_prewrite", dbg_data, m_regs[rd]);
    if (lg) begin
      m_regs[rd] = r[15:0];
      m_psr      = r[20:16];
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("done_idle", {31'b0, done}, 32'd0);
    check("illegal_idle", {31'b0, illegal}, 32'd0);
    check("ready_idle", {31'b0, instr_ready}, 32'd1);
    check("dbg_post", dbg_data, m_regs[rd]);
    check("psr", psr, m_psr);
  endtask

  initial begin
    logic [15:0] legal_tbl [8];
    int          done_seen;
    legal_tbl = '{16'h0050, 16'h0060, 16'h0070, 16'hA050, 16'hA060, 16'h5000, 16'h6000, 16'h7000};
    clk = 1'b0; reset = 1'b1; instr_valid = 1'b0; instr_in = '0; dbg_addr = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_psr", psr, 32'd0);
    check("rst_alu", {alu_A, alu_B}, 32'd0);
    check("rst_ctl", {alu_opcode, alu_opext, alu_carry}, 32'd0);
    reset = 1'b0;
    sweep_regs("rst_regs");

    // ADDUI R1,#0xFF
    issue(16'h61FF, 1'b0);
    dbg_addr = 4'd1; #1;
    check("addui_r1", dbg_data, 16'h00FF);
    check("addui_psr", psr, 5'b00000);

    // ADDI sign-extends, then ADDU R1,R1 sets carry
    do_reset();
    issue(16'h51FF, 1'b0);
    issue(16'h0161, 1'b0);
    dbg_addr = 4'd1; #1;
    check("addu_r1", dbg_data, 16'hFFFE);
    check("addu_c", {31'b0, psr[4]}, 32'd1);

    // Carry chain: carry produced by the previous instruction feeds ADDC
    issue(16'h6201, 1'b0);
    issue(16'h6302, 1'b0);
    issue(16'h0161, 1'b0);
    issue(16'h0273, 1'b0);
    dbg_addr = 4'd2; #1;
    check("addc_r2", dbg_data, 16'h0004);
    check("addc_cz", {30'b0, psr[4], psr[1]}, 32'd0);

    // Signed overflow: 0x7FFF + 1
    do_reset();
    issue(16'h54FF, 1'b0);
    issue(16'h6780, 1'b0);
    repeat (8) issue(16'h0757, 1'b0);
    issue(16'h0467, 1'b0);
    issue(16'h6501, 1'b0);
    issue(16'h0455, 1'b0);
    dbg_addr = 4'd4; #1;
    check("ovf_r4", dbg_data, 16'h8000);
    check("ovf_f", {31'b0, psr[2]}, 32'd1);

    // Illegal encoding leaves everything untouched
    issue(16'hF123, 1'b0);
    sweep_regs("illegal_regs");

    // Valid held through busy, then reset in EXEC aborts the instruction
    instr_in = 16'h6A05; instr_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; instr_valid = 1'b0;
    model_reset();
    check("abort_ready", {31'b0, instr_ready}, 32'd1);
    check("abort_psr", psr, 32'd0);
    check("abort_alu", alu_A, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    check("abort_no_done", done_seen, 32'd0);
    dbg_addr = 4'd10; #1;
    check("abort_r10", dbg_data, 16'h0000);

    // Randomized mix of legal and arbitrary encodings, some with valid held while busy
    for (int k = 0; k < 120; k++) begin
      logic [15:0] ins;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8) ins = legal_tbl[sel] | {4'h0, 4'($urandom), (legal_tbl[sel][15:12] == 4'h0 ||
                                           legal_tbl[sel][15:12] == 4'hA) ? 4'h0 : 4'($urandom),
                                           4'($urandom)};
      else         ins = 16'($urandom);
      issue(ins, 1'($urandom));
    end
    sweep_regs("final_regs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
